burst_seq_ctrl: RTL and testbench
=================================

BURST_SEQ_CTRL -- requirements
Module: burst_seq_ctrl

Interface
REQ-001 The block SHALL have one parameter: CNT_W, default 5, width of the sequenced up/down counter.
REQ-002 The block SHALL have port clk, input, 1, the single clock, with all state updated on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1, a request to begin one fill/drain burst, honoured only in IDLE.
REQ-005 The block SHALL have port abort, input, 1, which cancels the current burst from any state.
REQ-006 The block SHALL have ports in_valid (input, 1), in_ready (output, 1) and in_last (input, 1), forming the fill-side handshake; in_last marks the final item.
REQ-007 The block SHALL have ports out_valid (output, 1) and out_ready (input, 1), forming the drain-side handshake.
REQ-008 The block SHALL have ports cntU (output, 1), cntD (output, 1) and rst5 (output, 1), which are the counter controls.
REQ-009 The block SHALL have ports count (input, CNT_W) and down_done (input, 1), which are the counter value and its zero flag.
REQ-010 The block SHALL have ports busy (output, 1), done (output, 1, single-cycle pulse) and full (output, 1).

Function
REQ-011 The FSM SHALL have exactly four states: IDLE, FILL, DRAIN and DONE.
REQ-012 In IDLE with start=1, the block SHALL assert rst5 for that cycle and go to FILL; otherwise it SHALL stay in IDLE.
REQ-013 In FILL, in_ready SHALL equal ~full, where full = (count == 2^CNT_W-1).
REQ-014 In FILL, cntU SHALL be asserted combinationally in the same cycle that in_valid && in_ready is true; there is exactly one increment per accepted item.
REQ-015 In FILL, an accept with in_last=1 SHALL cause a transition to DRAIN.
REQ-016 In FILL, an accept while count == 2^CNT_W-2 SHALL cause a transition to DRAIN (saturation); the counter never wraps.
REQ-017 In DRAIN, out_valid SHALL equal ~down_done, and cntD SHALL equal out_valid && out_ready.
REQ-018 In DRAIN, a transfer while count == 1 SHALL cause a transition to DONE.
REQ-019 In DRAIN, if down_done=1 is observed, the block SHALL go to DONE; this is a defensive path only.
REQ-020 In DONE, the block SHALL assert done for exactly one cycle and then go to IDLE.
REQ-021 cntU and cntD SHALL never be asserted in the same cycle.
REQ-022 cntU and cntD SHALL be 0 in IDLE and DONE.
REQ-023 When abort=1 in any non-IDLE state, the block SHALL assert rst5, suppress cntU, cntD and done, and go to IDLE next cycle; abort has priority over every handshake in the same cycle.
REQ-024 start SHALL be ignored outside IDLE, and start together with abort in IDLE SHALL have no effect.
REQ-025 busy SHALL be 1 in every state other than IDLE.
REQ-026 in_ready SHALL be 0 outside FILL, and out_valid SHALL be 0 outside DRAIN.
REQ-027 The block SHALL add no latency: the counter observes each handshake on the same clock edge as the transfer.

Reset
REQ-028 While rst=1, state SHALL be IDLE.
REQ-029 While rst=1, the outputs SHALL be in_ready=0, out_valid=0, cntU=0, cntD=0, rst5=0, busy=0 and done=0.
REQ-030 The block SHALL act on reset immediately, without waiting for clk.
REQ-031 Reset in the middle of a burst SHALL discard the burst without a done pulse; the counter is cleared by its own reset.

Structure
REQ-032 The state encoding typedef and the full constant SHALL live in the shared package.
REQ-033 The counter SHALL be instantiated by the parent and connected through the ports above; no sub-module is instantiated inside this block.

Verification
REQ-034 Normal burst: start, then 3 accepts with in_last on the 3rd -> count reaches 3 and the block enters DRAIN; 3 drains -> count 0, a done pulse in the next cycle, then IDLE.
REQ-035 Saturation: 31 accepts with no in_last -> full=1, in_ready=0, auto-DRAIN, and 31 drains before done.
REQ-036 Back-pressure: hold out_ready=0 for 5 cycles in DRAIN -> out_valid stays 1, cntD stays 0, and count holds its value.
REQ-037 Abort mid-FILL at count=7 -> rst5 is pulsed, no done, IDLE next cycle, and the next start works normally.
REQ-038 Async reset asserted between edges during DRAIN -> busy=0 and out_valid=0 before the next clk edge.
REQ-039 Start while busy -> ignored, with the burst sequence unchanged.

Source files
------------

// File: rtl/burst_seq_ctrl_pkg.sv
// Shared definitions for the burst fill/drain sequencer: state encoding and
// the counter full-scale value.
package burst_seq_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FILL  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam int unsigned CNT_W_DEFAULT = 5;

   // All-ones value of a counter of the given width; this is the "full" level.
   function automatic int unsigned full_count(input int unsigned width);
      return (32'd1 << width) - 32'd1;
   endfunction

endpackage

// File: rtl/burst_seq_ctrl.sv
// Fill/drain burst sequencer that steers an external up/down counter through
// one burst: accept items until in_last or saturation, then drain to zero.
module burst_seq_ctrl
   import burst_seq_ctrl_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             cntU,
   output logic             cntD,
   output logic             rst5,
   input  logic [CNT_W-1:0] count,
   input  logic             down_done,
   output logic             busy,
   output logic             done,
   output logic             full
);

   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(full_count(CNT_W));
   localparam logic [CNT_W-1:0] SAT_CNT  = FULL_CNT - CNT_W'(1);
   localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

   state_t state;
   logic   abort_act;
   logic   launch;
   logic   accept;
   logic   xfer;

   // Handshake outputs are combinational so the counter moves on the same
   // edge as the transfer it counts.
   assign full      = (count == FULL_CNT);
   assign in_ready  = (state == ST_FILL) && !full;
   assign out_valid = (state == ST_DRAIN) && !down_done;

   assign abort_act = abort && (state != ST_IDLE);
   // NOTE: state already reads IDLE during reset, but start is a raw input, so
   // the launch term is gated by rst to keep rst5 low while reset is held.
   assign launch    = (state == ST_IDLE) && start && !abort && !rst;
   assign accept    = in_valid && in_ready && !abort;
   assign xfer      = out_valid && out_ready && !abort;

   assign cntU = accept;
   assign cntD = xfer;
   assign rst5 = launch || abort_act;
   assign busy = (state != ST_IDLE);
   assign done = (state == ST_DONE) && !abort;

   // NOTE: state is sequential, so it is written only with non-blocking
   // assignments; the async reset branch comes first.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else if (abort_act) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (launch) state <= ST_FILL;
            end
            ST_FILL: begin
               // Leaving at SAT_CNT means the final accept lands on FULL_CNT.
               if (accept && (in_last || count == SAT_CNT)) state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (down_done || (xfer && count == ONE_CNT)) state <= ST_DONE;
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_burst_seq_ctrl.sv
// Self-checking bench for burst_seq_ctrl: a local up/down counter stands in for
// the parent's counter, and an item-count model predicts every output.
module tb_burst_seq_ctrl;

   localparam int CNT_W = 5;
   localparam int MAXV  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic             abort;
   logic             in_valid;
   logic             in_ready;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic             cntU;
   logic             cntD;
   logic             rst5;
   logic [CNT_W-1:0] count;
   logic             down_done;
   logic             busy;
   logic             done;
   logic             full;

   int total = 0;
   int bad   = 0;

   // Reference model: which part of the burst we are in and how many items
   // the burst currently holds.
   typedef enum {M_IDLE, M_FILL, M_DRAIN, M_DONE} mphase_t;
   mphase_t m_phase;
   int      m_items;

   burst_seq_ctrl #(.CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .abort     (abort),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .cntU      (cntU),
      .cntD      (cntD),
      .rst5      (rst5),
      .count     (count),
      .down_done (down_done),
      .busy      (busy),
      .done      (done),
      .full      (full)
   );

   always #5 clk = ~clk;

   // The parent's counter, cleared by its own reset or by rst5.
   always @(posedge clk or posedge rst) begin
      if (rst)       count <= '0;
      else if (rst5) count <= '0;
      else if (cntU) count <= count + 1'b1;
      else if (cntD) count <= count - 1'b1;
   end
   assign down_done = (count == '0);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive inputs after the falling edge, check every output
   // against the model, then advance the model to the next cycle.
   task automatic step(input logic st, input logic ab, input logic iv,
                       input logic il, input logic orr);
      logic e_full, e_in_ready, e_out_valid, acc, xf, e_rst5, e_done, e_busy;
      @(negedge clk);
      start = st; abort = ab; in_valid = iv; in_last = il; out_ready = orr;
      #1;
      e_full      = (m_items == MAXV);
      e_in_ready  = (m_phase == M_FILL) && !e_full;
      e_out_valid = (m_phase == M_DRAIN) && (m_items != 0);
      acc         = e_in_ready && iv && !ab;
      xf          = e_out_valid && orr && !ab;
      e_rst5      = (m_phase == M_IDLE) ? (st && !ab) : ab;
      e_done      = (m_phase == M_DONE) && !ab;
      e_busy      = (m_phase != M_IDLE);
      check("count",     32'(count),     32'(m_items));
      check("busy",      32'(busy),      32'(e_busy));
      check("in_ready",  32'(in_ready),  32'(e_in_ready));
      check("out_valid", 32'(out_valid), 32'(e_out_valid));
      check("cntU",      32'(cntU),      32'(acc));
      check("cntD",      32'(cntD),      32'(xf));
      check("rst5",      32'(rst5),      32'(e_rst5));
      check("done",      32'(done),      32'(e_done));
      check("full",      32'(full),      32'(e_full));
      if (m_phase != M_IDLE && ab) begin
         m_phase = M_IDLE;
         m_items = 0;
      end else begin
         case (m_phase)
            M_IDLE: if (st && !ab) begin m_phase = M_FILL; m_items = 0; end
            M_FILL: if (acc) begin
               m_items++;
               if (il || m_items == MAXV) m_phase = M_DRAIN;
            end
            M_DRAIN: begin
               if (m_items == 0) m_phase = M_DONE;
               else if (xf) begin
                  m_items--;
                  if (m_items == 0) m_phase = M_DONE;
               end
            end
            M_DONE:  m_phase = M_IDLE;
            default: m_phase = M_IDLE;
         endcase
      end
   endtask

   task automatic fill(input int n, input bit last_on_final);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, last_on_final && (i == n - 1), 1'b0);
   endtask

   // Drain with out_ready held high until the model is idle, then one idle
   // cycle that also confirms the block has settled.
   task automatic drain_until_idle(input int budget);
      int k;
      k = 0;
      while (m_phase != M_IDLE && k < budget) begin
         step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
         k++;
      end
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("settled_idle", 32'(busy), 32'(0));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic st, ab, iv, il, orr;
      int   k;
      m_phase = M_IDLE;
      m_items = 0;
      // Reset held with start asserted: everything must stay quiet.
      rst = 1'b1; start = 1'b1; abort = 1'b0; in_valid = 1'b1; in_last = 1'b0; out_ready = 1'b1;
      @(negedge clk); #1;
      check("rst_busy",      32'(busy),      32'(0));
      check("rst_in_ready",  32'(in_ready),  32'(0));
      check("rst_out_valid", 32'(out_valid), 32'(0));
      check("rst_cntU",      32'(cntU),      32'(0));
      check("rst_cntD",      32'(cntD),      32'(0));
      check("rst_rst5",      32'(rst5),      32'(0));
      check("rst_done",      32'(done),      32'(0));
      check("rst_count",     32'(count),     32'(0));
      rst = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;

      // Normal burst of three items.
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      fill(3, 1'b1);
      drain_until_idle(10);

      // Back-pressure: five stalled drain cycles.
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      fill(4, 1'b1);
      repeat (5) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      drain_until_idle(10);

      // start held high throughout a burst is ignored.
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      k = 0;
      while (m_phase != M_IDLE && k < 10) begin
         step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
         k++;
      end
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Saturation: 31 accepts then two more offered while full.
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (MAXV + 2) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      drain_until_idle(MAXV + 5);

      // Abort mid-fill at count 7 with an item offered, then a normal burst.
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      fill(7, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      fill(2, 1'b1);
      drain_until_idle(10);

      // Abort in the middle of a drain transfer.
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      fill(5, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Abort in the done cycle suppresses the pulse.
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      fill(1, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // start together with abort in idle does nothing.
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Randomised bursts with noise on start and rare aborts.
      for (int b = 0; b < 25; b++) begin
         step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
         k = 0;
         while (m_phase != M_IDLE && k < 300) begin
            st  = ($urandom_range(0, 4) == 0);
            ab  = ($urandom_range(0, 99) == 0);
            iv  = ($urandom_range(0, 3) != 0);
            il  = ($urandom_range(0, 9) == 0);
            orr = ($urandom_range(0, 2) != 0);
            step(st, ab, iv, il, orr);
            k++;
         end
         step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         check("rand_settled", 32'(busy), 32'(0));
      end

      // Asynchronous reset between edges during a drain.
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      fill(6, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
      #1;
      check("pre_rst_busy",      32'(busy),      32'(1));
      check("pre_rst_out_valid", 32'(out_valid), 32'(1));
      #1;
      rst = 1'b1;
      #1;
      check("async_busy",      32'(busy),      32'(0));
      check("async_out_valid", 32'(out_valid), 32'(0));
      check("async_cntD",      32'(cntD),      32'(0));
      check("async_done",      32'(done),      32'(0));
      check("async_count",     32'(count),     32'(0));
      m_phase = M_IDLE;
      m_items = 0;
      @(posedge clk); #1;
      check("async_hold_busy", 32'(busy), 32'(0));
      @(negedge clk);
      rst = 1'b0; out_ready = 1'b0;

      // A clean burst after the reset.
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      fill(2, 1'b1);
      drain_until_idle(10);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
